// File: rtl/coin_feeder_pkg.sv
// Shared definitions for the coin sequencer: FSM encoding, table terminator
// and the saturating adder used for the running total.
package coin_feeder_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_FETCH    = 2'd1,
        S_WAIT_REL = 2'd2,
        S_END      = 2'd3
    } state_t;

    localparam int COIN_END = 0;

    // Adds at one bit wider than the operands, then clamps to the all-ones value of width w.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int          w);
        logic [32:0] sum;
        logic [32:0] limit;
        sum   = {1'b0, a} + {1'b0, b};
        limit = (33'd1 << w) - 33'd1;
        return (sum > limit) ? limit[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/coin_feeder_rise_detect.sv
// Rising-edge detector for a level that is already synchronous to clk.
// The delayed copy updates every cycle so a held level never re-triggers.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic sig,
    output logic rise
);

    logic sig_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sig_q <= 1'b0;
        else        sig_q <= sig;
    end

    assign rise = sig & ~sig_q;

endmodule

// File: rtl/coin_feeder.sv
// Purchase-side coin sequencer: each press of next fetches one table entry,
// presents it for a cycle and accumulates it into a saturating total.
//
// state      | meaning
// S_IDLE     | waiting for a rising edge on next
// S_FETCH    | table word at ptr is sampled on the leaving edge
// S_WAIT_REL | fetch done, waiting for next to drop
// S_END      | zero entry or table end reached; only sold/reset leave
module coin_feeder
    import coin_feeder_pkg::*;
#(
    parameter int COIN_W  = 5,
    parameter int DEPTH   = 32,
    parameter int PTR_W   = $clog2(DEPTH),
    parameter int TOTAL_W = 8,
    parameter bit WRAP    = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               next,
    input  logic               sold,
    output logic [PTR_W-1:0]   mem_addr,
    input  logic [COIN_W-1:0]  mem_data,
    output logic [COIN_W-1:0]  coin,
    output logic               coin_valid,
    output logic [TOTAL_W-1:0] total,
    output logic [PTR_W-1:0]   ptr,
    output logic               list_end,
    output logic               busy
);

    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    state_t             state, state_nxt;
    logic [PTR_W-1:0]   ptr_nxt;
    logic [COIN_W-1:0]  coin_nxt;
    logic [TOTAL_W-1:0] total_nxt;
    logic               valid_nxt;
    logic               rise;

    rise_detect u_rise (
        .clk   (clk),
        .reset (reset),
        .sig   (next),
        .rise  (rise)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            ptr        <= '0;
            coin       <= '0;
            total      <= '0;
            coin_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            ptr        <= ptr_nxt;
            coin       <= coin_nxt;
            total      <= total_nxt;
            coin_valid <= valid_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        coin_nxt  = coin;
        total_nxt = total;
        valid_nxt = 1'b0;
        case (state)
            S_IDLE: if (rise) state_nxt = S_FETCH;
            S_FETCH: begin
                if (mem_data == COIN_W'(COIN_END)) begin
                    state_nxt = S_END;
                end else begin
                    coin_nxt  = mem_data;
                    valid_nxt = 1'b1;
                    total_nxt = TOTAL_W'(sat_add(32'(total), 32'(mem_data), TOTAL_W));
                    if (ptr == LAST && !WRAP) begin
                        state_nxt = S_END;
                    end else begin
                        ptr_nxt   = (ptr == LAST) ? '0 : ptr + 1'b1;
                        state_nxt = S_WAIT_REL;
                    end
                end
            end
            S_WAIT_REL: if (!next) state_nxt = S_IDLE;
            S_END:      state_nxt = S_END;
            default:    state_nxt = S_IDLE;
        endcase
        // A sale discards whatever the FSM decided this cycle, including a completing fetch.
        if (sold) begin
            state_nxt = S_IDLE;
            ptr_nxt   = '0;
            coin_nxt  = '0;
            total_nxt = '0;
            valid_nxt = 1'b0;
        end
    end

    assign mem_addr = ptr;
    assign list_end = (state == S_END);
    assign busy     = (state == S_FETCH) || (state == S_WAIT_REL);

endmodule

// File: tb/tb_coin_feeder.sv
// Bench for coin_feeder: four configurations, coin_valid pulses checked
// against a per-instance expectation queue, control state checked directly.
module tb_coin_feeder;
    import coin_feeder_pkg::*;

    typedef struct {
        int coin;
        int total;
        int ptr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] nxt;
    logic [3:0] sld;

    int   tests = 0;
    int   fails = 0;
    int   vcnt[4];
    exp_t sb[4][$];

    logic [4:0] tab0[32];
    logic [4:0] tab1[32];
    logic [4:0] tab2[4];

    always #5 clk = ~clk;

    // default configuration
    logic [4:0] a0, d0, c0, p0;
    logic [7:0] t0;
    logic       v0, e0, b0;
    // TOTAL_W = 5
    logic [4:0] a1, d1, c1, p1, t1;
    logic       v1, e1, b1;
    // DEPTH = 3, WRAP = 1
    logic [1:0] a2, p2;
    logic [4:0] d2, c2;
    logic [7:0] t2;
    logic       v2, e2, b2;
    // DEPTH = 3, WRAP = 0
    logic [1:0] a3, p3;
    logic [4:0] d3, c3;
    logic [7:0] t3;
    logic       v3, e3, b3;

    assign d0 = tab0[a0];
    assign d1 = tab1[a1];
    assign d2 = tab2[a2];
    assign d3 = tab2[a3];

    coin_feeder #(.COIN_W(5), .DEPTH(32), .TOTAL_W(8), .WRAP(1'b0)) u_main (
        .clk(clk), .reset(rst), .next(nxt[0]), .sold(sld[0]), .mem_addr(a0), .mem_data(d0),
        .coin(c0), .coin_valid(v0), .total(t0), .ptr(p0), .list_end(e0), .busy(b0));

    coin_feeder #(.COIN_W(5), .DEPTH(32), .TOTAL_W(5), .WRAP(1'b0)) u_sat (
        .clk(clk), .reset(rst), .next(nxt[1]), .sold(sld[1]), .mem_addr(a1), .mem_data(d1),
        .coin(c1), .coin_valid(v1), .total(t1), .ptr(p1), .list_end(e1), .busy(b1));

    coin_feeder #(.COIN_W(5), .DEPTH(3), .TOTAL_W(8), .WRAP(1'b1)) u_wrap (
        .clk(clk), .reset(rst), .next(nxt[2]), .sold(sld[2]), .mem_addr(a2), .mem_data(d2),
        .coin(c2), .coin_valid(v2), .total(t2), .ptr(p2), .list_end(e2), .busy(b2));

    coin_feeder #(.COIN_W(5), .DEPTH(3), .TOTAL_W(8), .WRAP(1'b0)) u_nowrap (
        .clk(clk), .reset(rst), .next(nxt[3]), .sold(sld[3]), .mem_addr(a3), .mem_data(d3),
        .coin(c3), .coin_valid(v3), .total(t3), .ptr(p3), .list_end(e3), .busy(b3));

    logic mv[4];
    int   mc[4], mt[4], mp[4];

    always_comb begin
        mv[0] = v0; mc[0] = int'(c0); mt[0] = int'(t0); mp[0] = int'(p0);
        mv[1] = v1; mc[1] = int'(c1); mt[1] = int'(t1); mp[1] = int'(p1);
        mv[2] = v2; mc[2] = int'(c2); mt[2] = int'(t2); mp[2] = int'(p2);
        mv[3] = v3; mc[3] = int'(c3); mt[3] = int'(t3); mp[3] = int'(p3);
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every coin_valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (mv[i] === 1'b1) begin
                exp_t e;
                vcnt[i]++;
                tests++;
                if (sb[i].size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_valid[%0d]: coin=%0d total=%0d ptr=%0d, expected no pulse",
                             i, mc[i], mt[i], mp[i]);
                end else begin
                    e = sb[i].pop_front();
                    if (mc[i] !== e.coin || mt[i] !== e.total || mp[i] !== e.ptr) begin
                        fails++;
                        $display("FAIL fetch[%0d]: coin/total/ptr=%0d/%0d/%0d, expected %0d/%0d/%0d",
                                 i, mc[i], mt[i], mp[i], e.coin, e.total, e.ptr);
                    end
                end
            end
        end
    end

    task automatic expect_fetch(input int i, input int c, input int t, input int p);
        exp_t e;
        e.coin = c; e.total = t; e.ptr = p;
        sb[i].push_back(e);
    endtask

    task automatic press(input int i);
        @(posedge clk); #1 nxt[i] = 1'b1;
        @(posedge clk); #1 nxt[i] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic sell(input int i);
        @(posedge clk); #1 sld[i] = 1'b1;
        @(posedge clk); #1 sld[i] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        foreach (tab0[k]) begin tab0[k] = 5'd0; tab1[k] = 5'd0; end
        tab0[0] = 5'd3; tab0[1] = 5'd5; tab0[2] = 5'd2;
        tab1[0] = 5'd20; tab1[1] = 5'd20; tab1[2] = 5'd5;
        tab2[0] = 5'd1; tab2[1] = 5'd2; tab2[2] = 5'd3; tab2[3] = 5'd0;
        foreach (vcnt[k]) vcnt[k] = 0;
        rst = 1'b0; nxt = '0; sld = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);

        check("rst_ptr", int'(p0), 0);
        check("rst_addr", int'(a0), 0);
        check("rst_coin", int'(c0), 0);
        check("rst_total", int'(t0), 0);
        check("rst_valid", int'(v0), 0);
        check("rst_end", int'(e0), 0);
        check("rst_busy", int'(b0), 0);

        // three fetches from {3,5,2,0}
        expect_fetch(0, 3, 3, 1);  press(0);
        expect_fetch(0, 5, 8, 2);  press(0);
        expect_fetch(0, 2, 10, 3); press(0);
        check("t1_pulses", vcnt[0], 3);

        // zero entry terminates
        press(0);
        check("t2_end", int'(e0), 1);
        check("t2_total", int'(t0), 10);
        check("t2_ptr", int'(p0), 3);
        check("t2_coin", int'(c0), 2);
        check("t2_busy", int'(b0), 0);
        press(0);
        check("t2_end_hold", int'(e0), 1);
        check("t2_ptr_hold", int'(p0), 3);
        check("t2_pulses", vcnt[0], 3);

        sell(0);
        check("sold_end", int'(e0), 0);
        check("sold_ptr", int'(p0), 0);
        check("sold_total", int'(t0), 0);
        check("sold_coin", int'(c0), 0);

        // held next fetches once
        expect_fetch(0, 3, 3, 1);
        @(posedge clk); #1 nxt[0] = 1'b1;
        repeat (10) @(posedge clk);
        #1 nxt[0] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("t3_held_pulses", vcnt[0], 4);
        check("t3_idle", int'(b0), 0);
        expect_fetch(0, 5, 8, 2); press(0);
        check("t3_repress_pulses", vcnt[0], 5);

        // sold on the FETCH-leaving edge discards the fetch
        @(posedge clk); #1 nxt[0] = 1'b1;
        @(posedge clk); #1;
        check("t4_in_fetch", int'(b0), 1);
        sld[0] = 1'b1; nxt[0] = 1'b0;
        @(posedge clk); #1 sld[0] = 1'b0;
        @(negedge clk);
        check("t4_ptr", int'(p0), 0);
        check("t4_total", int'(t0), 0);
        check("t4_coin", int'(c0), 0);
        check("t4_valid", int'(v0), 0);
        check("t4_idle", int'(b0), 0);
        check("t4_pulses", vcnt[0], 5);

        // next held through sold must not refetch
        @(posedge clk); #1 nxt[0] = 1'b1;
        @(posedge clk); #1 sld[0] = 1'b1;
        @(posedge clk); #1 sld[0] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t4_held_idle", int'(b0), 0);
        check("t4_held_pulses", vcnt[0], 5);
        nxt[0] = 1'b0;

        // saturation with TOTAL_W=5
        expect_fetch(1, 20, 20, 1); press(1);
        expect_fetch(1, 20, 31, 2); press(1);
        expect_fetch(1, 5, 31, 3);  press(1);
        check("t5_total_sat", int'(t1), 31);
        check("t5_pulses", vcnt[1], 3);
        sell(1);
        check("t5_sold_total", int'(t1), 0);

        // DEPTH=3 with and without wrap
        expect_fetch(2, 1, 1, 1); press(2);
        expect_fetch(2, 2, 3, 2); press(2);
        expect_fetch(2, 3, 6, 0); press(2);
        expect_fetch(2, 1, 7, 1); press(2);
        check("t6_wrap_ptr", int'(p2), 1);
        check("t6_wrap_end", int'(e2), 0);
        check("t6_wrap_pulses", vcnt[2], 4);

        expect_fetch(3, 1, 1, 1); press(3);
        expect_fetch(3, 2, 3, 2); press(3);
        expect_fetch(3, 3, 6, 2); press(3);
        check("t6_nowrap_end", int'(e3), 1);
        check("t6_nowrap_ptr", int'(p3), 2);
        press(3);
        check("t6_nowrap_pulses", vcnt[3], 3);
        check("t6_nowrap_ptr_hold", int'(p3), 2);

        // async reset in the middle of a fetch
        @(posedge clk); #1 nxt[0] = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        #2;
        check("arst_busy", int'(b0), 0);
        check("arst_ptr", int'(p0), 0);
        nxt[0] = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("arst_total", int'(t0), 0);
        check("arst_coin", int'(c0), 0);
        check("arst_pulses", vcnt[0], 5);

        for (int i = 0; i < 4; i++) check($sformatf("sb_drained[%0d]", i), sb[i].size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
